// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I pipeline front end.
//   NOP           : canonical bubble instruction (addi x0, x0, 0)
//   fetch_state_e : fetch-stage control states
//   bswap32       : byte reversal used for little-endian instruction memory
package rv_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        REDIR = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry instruction hold buffer for the fetch stage.
// Captures a fetched word while the pipeline is stalled so the I-cache
// need not be re-read.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture load_data, mark valid
//   load_data   : word to capture
//   consume     : entry has been used, mark empty
//   clear       : discard entry (takes priority over load)
//   data        : buffered word
//   valid       : buffer holds a word
module fetch_hold_buf
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        consume,
    input  logic        clear,
    output logic [31:0] data,
    output logic        valid
);

    logic [31:0] data_d, data_q;
    logic        valid_d, valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= NOP;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage RV32I pipeline.
// Owns the PC and the IF/ID register, drives the I-cache read port, and
// absorbs I-cache miss latency with a hold buffer and a pending redirect.
//   clk, rst_n        : clock, asynchronous active-low reset
//   hazard_stall      : load-use stall, hold PC and IF/ID
//   hazard_flush      : write a bubble into IF/ID
//   branch_taken      : redirect request (single-cycle pulse)
//   branch_target     : redirect PC, word aligned
//   dc_stall          : global pipeline freeze
//   ic_read, ic_addr  : I-cache request, word address PC[31:2]
//   ic_rdata          : I-cache data, valid when ic_read=1 and ic_stall=0
//   ic_stall          : I-cache busy, address held stable
//   ifid_pc/inst/valid: IF/ID pipeline register
module fetch_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter bit          SWAP_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hazard_stall,
    input  logic        hazard_flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        dc_stall,
    output logic        ic_read,
    output logic [29:0] ic_addr,
    input  logic [31:0] ic_rdata,
    input  logic        ic_stall,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_inst,
    output logic        ifid_valid
);

    fetch_state_e state_d, state_q;
    logic [31:0]  pc_d, pc_q;
    logic [31:0]  redir_pc_d, redir_pc_q;
    logic [31:0]  ifid_pc_d, ifid_pc_q;
    logic [31:0]  ifid_inst_d, ifid_inst_q;
    logic         ifid_valid_d, ifid_valid_q;

    logic         buf_load, buf_consume, buf_clear;
    logic [31:0]  buf_data;
    logic         buf_valid;
    logic [31:0]  fetch_word;

    assign fetch_word = SWAP_ENDIAN ? bswap32(ic_rdata) : ic_rdata;

    fetch_hold_buf u_hold_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .load_data (fetch_word),
        .consume   (buf_consume),
        .clear     (buf_clear),
        .data      (buf_data),
        .valid     (buf_valid)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pc_d   = redir_pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_valid_d = ifid_valid_q;
        buf_load     = 1'b0;
        buf_consume  = 1'b0;
        buf_clear    = 1'b0;

        if (!dc_stall) begin
            unique case (state_q)
                RUN: begin
                    if (branch_taken) begin
                        ifid_valid_d = 1'b0;
                        ifid_inst_d  = NOP;
                        if (!ic_stall) begin
                            pc_d = branch_target;
                        end else begin
                            // Miss outstanding: keep ic_addr stable, redirect later.
                            redir_pc_d = branch_target;
                            state_d    = REDIR;
                        end
                    end else if (hazard_flush) begin
                        ifid_valid_d = 1'b0;
                        ifid_inst_d  = NOP;
                        if (!ic_stall) begin
                            if (hazard_stall) begin
                                buf_load = 1'b1;
                                state_d  = HOLD;
                            end else begin
                                pc_d = pc_q + 32'd4;
                            end
                        end
                    end else if (hazard_stall) begin
                        if (!ic_stall) begin
                            buf_load = 1'b1;
                            state_d  = HOLD;
                        end
                    end else if (!ic_stall) begin
                        ifid_pc_d    = pc_q;
                        ifid_inst_d  = fetch_word;
                        ifid_valid_d = 1'b1;
                        pc_d         = pc_q + 32'd4;
                    end else begin
                        ifid_valid_d = 1'b0;
                        ifid_inst_d  = NOP;
                    end
                end

                REDIR: begin
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = NOP;
                    if (!ic_stall) begin
                        // Returned word belongs to the old path and is dropped.
                        pc_d    = branch_taken ? branch_target : redir_pc_q;
                        state_d = RUN;
                    end else if (branch_taken) begin
                        redir_pc_d = branch_target;
                    end
                end

                HOLD: begin
                    if (branch_taken) begin
                        buf_clear    = 1'b1;
                        pc_d         = branch_target;
                        ifid_valid_d = 1'b0;
                        ifid_inst_d  = NOP;
                        state_d      = RUN;
                    end else if (hazard_flush) begin
                        ifid_valid_d = 1'b0;
                        ifid_inst_d  = NOP;
                        if (!hazard_stall) begin
                            buf_clear = 1'b1;
                            pc_d      = pc_q + 32'd4;
                            state_d   = RUN;
                        end
                    end else if (!hazard_stall) begin
                        ifid_pc_d    = pc_q;
                        ifid_inst_d  = buf_data;
                        ifid_valid_d = buf_valid;
                        buf_consume  = 1'b1;
                        pc_d         = pc_q + 32'd4;
                        state_d      = RUN;
                    end
                end

                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            redir_pc_q   <= '0;
            ifid_pc_q    <= '0;
            ifid_inst_q  <= NOP;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pc_q   <= redir_pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // Read is requested from the first cycle out of reset, except while
    // the instruction is supplied by the hold buffer.
    assign ic_read    = rst_n && (state_q != HOLD);
    assign ic_addr    = pc_q[31:2];
    assign ifid_pc    = ifid_pc_q;
    assign ifid_inst  = ifid_inst_q;
    assign ifid_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        hazard_stall;
    logic        hazard_flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        dc_stall;
    logic        ic_read;
    logic [29:0] ic_addr;
    logic [31:0] ic_rdata;
    logic        ic_stall;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic        ifid_valid;

    int n_total;
    int n_bad;

    fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .SWAP_ENDIAN (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hazard_stall  (hazard_stall),
        .hazard_flush  (hazard_flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .dc_stall      (dc_stall),
        .ic_read       (ic_read),
        .ic_addr       (ic_addr),
        .ic_rdata      (ic_rdata),
        .ic_stall      (ic_stall),
        .ifid_pc       (ifid_pc),
        .ifid_inst     (ifid_inst),
        .ifid_valid    (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction expected in IF/ID for a given word address.
    function automatic logic [31:0] exp_word(input logic [29:0] a);
        return {2'b10, a};
    endfunction

    // Little-endian memory image of a word.
    function automatic logic [31:0] le_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign ic_rdata = le_bytes(exp_word(ic_addr));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        hazard_stall  = 1'b0;
        hazard_flush  = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        dc_stall      = 1'b0;
        ic_stall      = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(ifid_valid), 32'd0);
        chk("rst_pc",    ifid_pc,         32'h0);
        chk("rst_inst",  ifid_inst,       32'h0000_0013);
        chk("rst_read",  32'(ic_read),    32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_read", 32'(ic_read), 32'd1);
        chk("first_addr", 32'(ic_addr), 32'd0);

        // Straight-line fetch
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("seq_pc",    ifid_pc,         32'((k - 1) * 4));
            chk("seq_inst",  ifid_inst,       exp_word(30'(k - 1)));
            chk("seq_valid", 32'(ifid_valid), 32'd1);
            chk("seq_addr",  32'(ic_addr),    32'(k));
        end

        // I-cache miss for 3 cycles at pc=0x10
        ic_stall = 1'b1;
        repeat (3) begin
            step();
            chk("ics_addr",  32'(ic_addr),    32'h4);
            chk("ics_valid", 32'(ifid_valid), 32'd0);
            chk("ics_read",  32'(ic_read),    32'd1);
        end
        ic_stall = 1'b0;
        step();
        chk("ics_pc",    ifid_pc,         32'h10);
        chk("ics_inst",  ifid_inst,       exp_word(30'h4));
        chk("ics_valid", 32'(ifid_valid), 32'd1);
        chk("ics_addr",  32'(ic_addr),    32'h5);

        for (int k = 5; k <= 7; k++) begin
            step();
            chk("run_pc",   ifid_pc,      32'(k * 4));
            chk("run_addr", 32'(ic_addr), 32'(k + 1));
        end

        // Load-use stall for 2 cycles at pc=0x20
        hazard_stall = 1'b1;
        repeat (2) begin
            step();
            chk("hs_read",  32'(ic_read),    32'd0);
            chk("hs_pc",    ifid_pc,         32'h1C);
            chk("hs_valid", 32'(ifid_valid), 32'd1);
        end
        hazard_stall = 1'b0;
        step();
        chk("hs_rel_pc",   ifid_pc,      32'h20);
        chk("hs_rel_inst", ifid_inst,    exp_word(30'h8));
        chk("hs_rel_addr", 32'(ic_addr), 32'h9);
        chk("hs_rel_read", 32'(ic_read), 32'd1);

        for (int k = 9; k <= 15; k++) begin
            step();
            chk("run_pc",   ifid_pc,      32'(k * 4));
            chk("run_addr", 32'(ic_addr), 32'(k + 1));
        end

        // Redirect during a miss at pc=0x40
        ic_stall      = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        step();
        chk("br_valid", 32'(ifid_valid), 32'd0);
        chk("br_addr",  32'(ic_addr),    32'h10);
        branch_taken = 1'b0;
        step();
        chk("br_hold_addr",  32'(ic_addr),    32'h10);
        chk("br_hold_valid", 32'(ifid_valid), 32'd0);
        ic_stall = 1'b0;
        step();
        chk("br_drop_addr",  32'(ic_addr),    32'h40);
        chk("br_drop_valid", 32'(ifid_valid), 32'd0);
        step();
        chk("br_tgt_pc",    ifid_pc,         32'h100);
        chk("br_tgt_inst",  ifid_inst,       exp_word(30'h40));
        chk("br_tgt_valid", 32'(ifid_valid), 32'd1);
        chk("br_tgt_addr",  32'(ic_addr),    32'h41);

        // D-cache freeze with a redirect held
        dc_stall      = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        repeat (4) begin
            step();
            chk("dc_addr",  32'(ic_addr),    32'h41);
            chk("dc_pc",    ifid_pc,         32'h100);
            chk("dc_valid", 32'(ifid_valid), 32'd1);
        end
        dc_stall = 1'b0;
        step();
        chk("dc_rel_addr",  32'(ic_addr),    32'h80);
        chk("dc_rel_valid", 32'(ifid_valid), 32'd0);
        branch_taken = 1'b0;
        step();
        chk("dc_tgt_pc",   ifid_pc,      32'h200);
        chk("dc_tgt_inst", ifid_inst,    exp_word(30'h80));
        chk("dc_tgt_addr", 32'(ic_addr), 32'h81);

        // Flush alone: bubble, fetched word lost, PC advances
        hazard_flush = 1'b1;
        step();
        chk("fl_valid", 32'(ifid_valid), 32'd0);
        chk("fl_inst",  ifid_inst,       32'h0000_0013);
        chk("fl_addr",  32'(ic_addr),    32'h82);
        hazard_flush = 1'b0;
        step();
        chk("fl_next_pc",   ifid_pc,   32'h208);
        chk("fl_next_inst", ifid_inst, exp_word(30'h82));

        // PC wrap at top of address space
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        chk("wr_addr", 32'(ic_addr), 32'h3FFF_FFFF);
        branch_taken = 1'b0;
        step();
        chk("wr_pc",   ifid_pc,      32'hFFFF_FFFC);
        chk("wr_inst", ifid_inst,    exp_word(30'h3FFF_FFFF));
        chk("wr_addr0", 32'(ic_addr), 32'h0);

        // Asynchronous reset while a redirect is pending
        ic_stall      = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h300;
        step();
        chk("rr_valid", 32'(ifid_valid), 32'd0);
        branch_taken = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(ifid_valid), 32'd0);
        chk("ar_read",  32'(ic_read),    32'd0);
        chk("ar_pc",    ifid_pc,         32'h0);
        chk("ar_inst",  ifid_inst,       32'h0000_0013);
        repeat (2) @(negedge clk);
        ic_stall = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("ar_rel_read", 32'(ic_read), 32'd1);
        chk("ar_rel_addr", 32'(ic_addr), 32'h0);
        step();
        chk("ar_run_pc",    ifid_pc,         32'h0);
        chk("ar_run_inst",  ifid_inst,       exp_word(30'h0));
        chk("ar_run_valid", 32'(ifid_valid), 32'd1);
        chk("ar_run_addr",  32'(ic_addr),    32'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
